line_window_buffer: RTL and testbench

- Streaming 3x3 window generator directly upstream of the 3x3 grayscale convolution stage.
- Accepts a raster-order pixel stream, one pixel per cycle, with arbitrary valid gaps.
- Buffers two previous image rows and emits every valid-mode (unpadded) 3x3 neighbourhood with a window-valid strobe that drives the convolution stage's data-valid input.
- Yields (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/line_buffer.sv | 30 +++
 rtl/line_window_buffer.sv | 137 +++++++++++++
 tb/tb_line_window_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN front end.
// Provides the pixel and 3x3 window types used by the window generator and the
// convolution stage that consumes its output.
package cnn_pkg;

  localparam int unsigned PIXEL_WIDTH = 8;
  localparam int unsigned KERNEL_SIZE = 3;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  // [r][c]: r=0 is the oldest (top) row, c=0 the oldest (leftmost) column.
  typedef pixel_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] window_t;

endpackage

// File: rtl/line_buffer.sv
// Single-port row buffer, RAM-inferable.
// Ports:
//   clk_i   - clock
//   en_i    - write enable; wdata_i is stored at addr_i on the rising edge
//   addr_i  - read/write address
//   wdata_i - write data
//   rdata_o - combinational read of mem[addr_i] (pre-write contents)
module line_buffer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  // Contents are deliberately not reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/line_window_buffer.sv
// Streaming 3x3 window generator feeding the convolution stage.
// Buffers the two previous rows of a raster-order pixel stream and emits every
// unpadded 3x3 neighbourhood, one cycle after the pixel that completes it.
// Ports:
//   clk_i          - clock, rising edge
//   rst_i          - synchronous active-high reset
//   pixel_i        - incoming pixel, raster order
//   pixel_valid_i  - pixel_i valid this cycle (no back-pressure)
//   sof_i          - start of frame, qualified by pixel_valid_i
//   window_o       - 3x3 window, [r][c], r=0 top row, c=0 leftmost column
//   window_valid_o - window_o valid this cycle
//   frame_done_o   - pulses with the last window of a frame
module line_window_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = 28,
  parameter int unsigned IMG_HEIGHT  = 28,
  parameter int unsigned PIXEL_WIDTH = cnn_pkg::PIXEL_WIDTH
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_i,
  input  logic [PIXEL_WIDTH-1:0]                                  pixel_i,
  input  logic                                                    pixel_valid_i,
  input  logic                                                    sof_i,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_WIDTH-1:0] window_o,
  output logic                                                    window_valid_o,
  output logic                                                    frame_done_o
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);

  typedef logic [ColW-1:0] col_t;
  typedef logic [RowW-1:0] row_t;
  typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_WIDTH-1:0] win_t;

  localparam col_t ColLast     = col_t'(IMG_WIDTH - 1);
  localparam row_t RowLast     = row_t'(IMG_HEIGHT - 1);
  localparam col_t FirstWinCol = col_t'(KERNEL_SIZE - 1);
  localparam row_t FirstWinRow = row_t'(KERNEL_SIZE - 1);

  col_t col_q, col_d, cur_col;
  row_t row_q, row_d, cur_row;
  win_t win_q, win_d;
  logic valid_q, valid_d;
  logic done_q, done_d;
  logic accept;

  logic [PIXEL_WIDTH-1:0] line1_rd, line2_rd;

  assign accept = pixel_valid_i & ~rst_i;

  // Position of the current pixel; sof forces (0,0) regardless of the counters.
  always_comb begin
    cur_col = sof_i ? '0 : col_q;
    cur_row = sof_i ? '0 : row_q;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pixel_valid_i) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? '0 : cur_row + row_t'(1);
      end else begin
        col_d = cur_col + col_t'(1);
        row_d = cur_row;
      end
    end
  end

  // line1 holds row-1, line2 holds row-2; line1's old word cascades into line2.
  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_WIDTH)
  ) u_line1 (
    .clk_i   (clk_i),
    .en_i    (accept),
    .addr_i  (cur_col),
    .wdata_i (pixel_i),
    .rdata_o (line1_rd)
  );

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_WIDTH)
  ) u_line2 (
    .clk_i   (clk_i),
    .en_i    (accept),
    .addr_i  (cur_col),
    .wdata_i (line1_rd),
    .rdata_o (line2_rd)
  );

  // Columns shift toward c=0; the new column enters at c=KERNEL_SIZE-1. The shift
  // also happens for edge pixels so the first window of a row is row-local.
  always_comb begin
    win_d = win_q;
    if (pixel_valid_i) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][KERNEL_SIZE-1] = line2_rd;
      win_d[1][KERNEL_SIZE-1] = line1_rd;
      win_d[2][KERNEL_SIZE-1] = pixel_i;
    end
  end

  always_comb begin
    valid_d = pixel_valid_i && (cur_row >= FirstWinRow) && (cur_col >= FirstWinCol);
    done_d  = valid_d && (cur_row == RowLast) && (cur_col == ColLast);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign window_o       = win_q;
  assign window_valid_o = valid_q;
  assign frame_done_o   = done_q;

endmodule

// File: tb/tb_line_window_buffer.sv
module tb_line_window_buffer;
  import cnn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4x4 instance
  logic    rst4, v4, sof4, wv4, fd4;
  pixel_t  pix4;
  window_t win4;
  // 28x28 instance
  logic    rst28, v28, sof28, wv28, fd28;
  pixel_t  pix28;
  window_t win28;

  line_window_buffer #(
    .IMG_WIDTH   (4),
    .IMG_HEIGHT  (4),
    .PIXEL_WIDTH (8)
  ) dut4 (
    .clk_i          (clk),
    .rst_i          (rst4),
    .pixel_i        (pix4),
    .pixel_valid_i  (v4),
    .sof_i          (sof4),
    .window_o       (win4),
    .window_valid_o (wv4),
    .frame_done_o   (fd4)
  );

  line_window_buffer #(
    .IMG_WIDTH   (28),
    .IMG_HEIGHT  (28),
    .PIXEL_WIDTH (8)
  ) dut28 (
    .clk_i          (clk),
    .rst_i          (rst28),
    .pixel_i        (pix28),
    .pixel_valid_i  (v28),
    .sof_i          (sof28),
    .window_o       (win28),
    .window_valid_o (wv28),
    .frame_done_o   (fd28)
  );

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  // trig is the accepted pixel that should have produced the window one cycle earlier.
  typedef struct {
    pixel_t  trig;
    window_t w;
    logic    done;
  } vec_t;

  vec_t tbl[4];
  vec_t q4[$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic window_t mkwin(input pixel_t a0, a1, a2, a3, a4, a5, a6, a7, a8);
    window_t w;
    w[0][0] = a0; w[0][1] = a1; w[0][2] = a2;
    w[1][0] = a3; w[1][1] = a4; w[1][2] = a5;
    w[2][0] = a6; w[2][1] = a7; w[2][2] = a8;
    return w;
  endfunction

  function automatic pixel_t pval28(input int f, input int idx);
    return pixel_t'(idx * 7 + f * 13 + 3);
  endfunction

  // ---------------- 4x4 monitor ----------------
  logic    acc4_prev = 1'b0, rst4_prev = 1'b1;
  pixel_t  pix4_prev;
  window_t win4_last = '0;

  always @(posedge clk) begin
    acc4_prev <= v4 && !rst4;
    rst4_prev <= rst4;
    pix4_prev <= pix4;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (wv4 === 1'b1) q4.push_back('{pix4_prev, win4, fd4});
      if (!acc4_prev) begin
        check("valid_in_gap", 72'(wv4), 72'(1'b0));
        check("done_in_gap", 72'(fd4), 72'(1'b0));
        if (!rst4_prev) check("window_hold", win4, win4_last);
      end
    end
    win4_last = win4;
  end

  // ---------------- 28x28 monitor ----------------
  int      wif28 = 0, fdcnt28 = 0, tot28 = 0;
  window_t first2 = '0;
  logic    got_first2 = 1'b0;

  always @(negedge clk) begin
    if (mon_en && wv28 === 1'b1) begin
      if (wif28 == 0 && fdcnt28 == 1) begin
        first2     = win28;
        got_first2 = 1'b1;
      end
      wif28++;
      tot28++;
      if (fd28 === 1'b1) begin
        check("frame28_windows", 72'(wif28), 72'(676));
        fdcnt28++;
        wif28 = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive4(input pixel_t p, input logic v, input logic s, input logic r);
    @(posedge clk);
    #1;
    pix4 = p; v4 = v; sof4 = s; rst4 = r;
  endtask

  task automatic idle4(input int n);
    repeat (n) drive4('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame4(input logic with_sof, input logic gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        repeat ($urandom_range(2, 0))
          drive4(pixel_t'($urandom), 1'b0, 1'($urandom_range(1, 0)), 1'b0);
      end
      drive4(pixel_t'(i), 1'b1, with_sof && (i == 0), 1'b0);
    end
  endtask

  task automatic check_frame(input string name);
    check({name, "_count"}, 72'(q4.size()), 72'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < q4.size()) begin
        check({name, "_trig"}, 72'(q4[i].trig), 72'(tbl[i].trig));
        check({name, "_win"}, q4[i].w, tbl[i].w);
        check({name, "_done"}, 72'(q4[i].done), 72'(tbl[i].done));
      end
    end
    q4.delete();
  endtask

  task automatic drive28(input pixel_t p, input logic v, input logic s);
    @(posedge clk);
    #1;
    pix28 = p; v28 = v; sof28 = s;
  endtask

  initial begin
    // Expected windows of a 4x4 frame with pixel = row*4+col.
    tbl[0] = '{8'd10, mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10), 1'b0};
    tbl[1] = '{8'd11, mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11), 1'b0};
    tbl[2] = '{8'd14, mkwin(4, 5, 6, 8, 9, 10, 12, 13, 14), 1'b0};
    tbl[3] = '{8'd15, mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15), 1'b1};

    rst4 = 1'b1; v4 = 1'b0; sof4 = 1'b0; pix4 = '0;
    rst28 = 1'b1; v28 = 1'b0; sof28 = 1'b0; pix28 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b0; rst28 = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    check("reset_valid", 72'(wv4), 72'(1'b0));
    check("reset_done", 72'(fd4), 72'(1'b0));
    check("reset_window", win4, '0);
    check("reset_valid28", 72'(wv28), 72'(1'b0));

    // Continuous frame
    send_frame4(1'b1, 1'b0);
    idle4(3);
    check_frame("nogap");

    // Same frame with random gaps and junk on the inputs while invalid
    send_frame4(1'b1, 1'b1);
    idle4(3);
    check_frame("gaps");

    // Nine stale pixels, then sof restarts the frame
    for (int i = 0; i < 9; i++) drive4(pixel_t'(100 + i), 1'b1, 1'b0, 1'b0);
    send_frame4(1'b1, 1'b0);
    idle4(3);
    check_frame("midsof");

    // Reset after pixel 11, then a frame without sof
    for (int i = 0; i < 12; i++) drive4(pixel_t'(200 + i), 1'b1, i == 0, 1'b0);
    drive4('0, 1'b0, 1'b0, 1'b1);
    drive4('0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_mid_valid", 72'(wv4), 72'(1'b0));
    check("rst_mid_done", 72'(fd4), 72'(1'b0));
    check("rst_mid_window", win4, '0);
    q4.delete();
    send_frame4(1'b0, 1'b0);
    idle4(3);
    check_frame("after_rst");

    // Two back-to-back 28x28 frames, sof only on the first
    for (int f = 0; f < 2; f++) begin
      for (int idx = 0; idx < 784; idx++) drive28(pval28(f, idx), 1'b1, f == 0 && idx == 0);
    end
    repeat (3) drive28('0, 1'b0, 1'b0);
    @(negedge clk);
    check("frame28_done_count", 72'(fdcnt28), 72'(2));
    check("frame28_total", 72'(tot28), 72'(1352));
    check("frame2_first_seen", 72'(got_first2), 72'(1'b1));
    check("frame2_first_win", first2,
          mkwin(pval28(1, 0), pval28(1, 1), pval28(1, 2),
                pval28(1, 28), pval28(1, 29), pval28(1, 30),
                pval28(1, 56), pval28(1, 57), pval28(1, 58)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
